// File: rtl/stoch_pkg.sv
`default_nettype none
// ============================================================================
// Package     : stoch_pkg
// Description : Types and constants shared by the stochastic-computing
//               blocks (LFSR probability generator and stochastic-to-binary
//               converter).
// Revision    : 1.0 - initial release
// ============================================================================
package stoch_pkg;

  // Default LFSR width; the converter window is one full LFSR period.
  localparam int LFSR_N = 7;

  // Converter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } s2b_state_t;

endpackage : stoch_pkg
`default_nettype wire

// File: rtl/stoch_to_bin.sv
`default_nettype none
// ============================================================================
// Module      : stoch_to_bin
// Description : Stochastic-to-binary converter. Counts the ones of the
//               single-bit stream prob_bit over 2^N-1 valid samples (one
//               maximal-length LFSR period) and presents the N-bit count on
//               a valid/ready output.
// Ports       : clk          - clock, rising edge
//               rst_b        - asynchronous active-low reset
//               start        - request to begin a conversion window
//               prob_bit     - stochastic input bit
//               bit_valid    - prob_bit is a valid sample this cycle
//               result       - ones count of the completed window
//               result_valid - result is valid
//               result_ready - downstream accepts result
//               busy         - window is accumulating
// Revision    : 1.0 - initial release
// ============================================================================
module stoch_to_bin
  import stoch_pkg::*;
#(
  parameter int N = LFSR_N
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic         prob_bit,
  input  logic         bit_valid,
  output logic [N-1:0] result,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         busy
);

  // Sample index of the final sample in a window (window is 2^N-1 samples,
  // counted from zero).
  localparam logic [N-1:0] LAST_SAMPLE = N'((2 ** N) - 2);

  s2b_state_t   state_q,        state_d;
  logic [N-1:0] sample_cnt_q,   sample_cnt_d;
  logic [N-1:0] ones_cnt_q,     ones_cnt_d;
  logic [N-1:0] result_q,       result_d;
  logic         result_valid_q, result_valid_d;

  // Ones count including the current bit; used both for the running
  // counter and for the final result so the last sample is not lost.
  logic [N-1:0] ones_inc;
  assign ones_inc = ones_cnt_q + N'(prob_bit);

  always_comb begin
    state_d        = state_q;
    sample_cnt_d   = sample_cnt_q;
    ones_cnt_d     = ones_cnt_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sample_cnt_d = '0;
          ones_cnt_d   = '0;
          state_d      = ACCUM;
        end
      end

      ACCUM: begin
        if (bit_valid) begin
          sample_cnt_d = sample_cnt_q + N'(1);
          ones_cnt_d   = ones_inc;
          if (sample_cnt_q == LAST_SAMPLE) begin
            result_d       = ones_inc;
            result_valid_d = 1'b1;
            state_d        = HOLD;
          end
        end
      end

      HOLD: begin
        if (result_valid_q && result_ready) begin
          result_valid_d = 1'b0;
          if (start) begin
            // Back-to-back window: first sample is taken on the next edge.
            sample_cnt_d = '0;
            ones_cnt_d   = '0;
            state_d      = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q        <= IDLE;
      sample_cnt_q   <= '0;
      ones_cnt_q     <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sample_cnt_q   <= sample_cnt_d;
      ones_cnt_q     <= ones_cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = (state_q == ACCUM);

endmodule : stoch_to_bin
`default_nettype wire

// File: tb/tb_stoch_to_bin.sv
`default_nettype none
// ============================================================================
// Module      : tb_stoch_to_bin
// Description : Self-checking bench for stoch_to_bin (N=7). Table of window
//               patterns with hand-computed counts and latencies, plus
//               sequences for backpressure, back-to-back, mid-window reset
//               and an end-to-end LFSR-fed conversion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stoch_to_bin;

  localparam int N = 7;

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic         start = 1'b0;
  logic         prob_bit = 1'b0;
  logic         bit_valid = 1'b0;
  logic         result_ready = 1'b0;
  logic [N-1:0] result;
  logic         result_valid;
  logic         busy;

  int errors = 0;
  int checks = 0;

  // Golden LFSR: x^7 + x^6 + 1, probability 0xaa compared on the low 7 bits.
  logic [6:0] lfsr_s = 7'h01;
  logic [6:0] prob7  = 7'h2a;

  always #5 clk = ~clk;

  stoch_to_bin #(.N(N)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .start        (start),
    .prob_bit     (prob_bit),
    .bit_valid    (bit_valid),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  typedef struct {
    int pm;       // prob_bit pattern
    int vm;       // bit_valid pattern
    int exp_res;  // expected ones count
    int exp_lat;  // cycle offset from start edge T where result_valid is seen
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [6:0] lfsr_step(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  function automatic logic vbit(input int vm, input int k);
    case (vm)
      1:       return (k % 2) == 0;
      2:       return (k % 4) != 3;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic pbit(input int pm, input int k, input logic v);
    case (pm)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (k % 3) == 0;
      3:       return !v;
      4:       return lfsr_s < prob7;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
  endtask

  // Feed samples from the cycle after the start edge until result_valid.
  task automatic accum(input int pm, input int vm, output int lat);
    lat = -1;
    for (int k = 0; k < 400; k++) begin
      bit_valid = vbit(vm, k);
      prob_bit  = pbit(pm, k, bit_valid);
      tick();
      if (pm == 4 && bit_valid) lfsr_s = lfsr_step(lfsr_s);
      if (result_valid) begin
        lat = k + 2;
        break;
      end
    end
    bit_valid = 1'b0;
    prob_bit  = 1'b0;
    if (lat < 0) check("window_timeout", 0, 1);
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("rv_after_handshake", int'(result_valid), 0);
    check("busy_after_handshake", int'(busy), 0);
  endtask

  initial begin
    int lat;
    int golden;
    int res_seed[2];
    logic [6:0] seeds[2];
    logic [6:0] s;

    vecs[0] = '{pm: 0, vm: 0, exp_res: 127, exp_lat: 128};
    vecs[1] = '{pm: 1, vm: 0, exp_res: 0,   exp_lat: 128};
    vecs[2] = '{pm: 0, vm: 1, exp_res: 127, exp_lat: 254};
    vecs[3] = '{pm: 3, vm: 1, exp_res: 0,   exp_lat: 254};
    vecs[4] = '{pm: 2, vm: 0, exp_res: 43,  exp_lat: 128};
    vecs[5] = '{pm: 0, vm: 2, exp_res: 127, exp_lat: 170};

    // Reset state
    #12;
    check("reset_result", int'(result), 0);
    check("reset_rv", int'(result_valid), 0);
    check("reset_busy", int'(busy), 0);
    #8 rst_b = 1'b1;
    tick();
    check("idle_busy", int'(busy), 0);

    // Table-driven windows
    for (int i = 0; i < 6; i++) begin
      launch();
      accum(vecs[i].pm, vecs[i].vm, lat);
      check($sformatf("vec%0d_result", i), int'(result), vecs[i].exp_res);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_busy_low", i), int'(busy), 0);
      handshake();
    end

    // Backpressure then back-to-back
    launch();
    accum(0, 0, lat);
    check("bp_latency", lat, 128);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_result_stable", int'(result), 127);
      check("bp_rv_stable", int'(result_valid), 1);
    end
    result_ready = 1'b1;
    start        = 1'b1;
    tick();
    result_ready = 1'b0;
    start        = 1'b0;
    check("b2b_busy", int'(busy), 1);
    check("b2b_rv_low", int'(result_valid), 0);
    accum(2, 0, lat);
    check("b2b_result", int'(result), 43);
    check("b2b_latency", lat, 128);
    handshake();

    // Reset mid-window at sample 60
    launch();
    bit_valid = 1'b1;
    prob_bit  = 1'b1;
    repeat (60) tick();
    #2 rst_b = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_rv", int'(result_valid), 0);
    check("mid_rst_result", int'(result), 0);
    bit_valid = 1'b0;
    prob_bit  = 1'b0;
    tick();
    #2 rst_b = 1'b1;
    tick();
    launch();
    accum(0, 0, lat);
    check("post_rst_result", int'(result), 127);
    check("post_rst_latency", lat, 128);
    handshake();

    // End-to-end LFSR-fed conversion, two seeds
    seeds[0] = 7'h4f;
    seeds[1] = 7'h01;
    for (int j = 0; j < 2; j++) begin
      golden = 0;
      s = seeds[j];
      for (int k = 0; k < 127; k++) begin
        if (s < prob7) golden++;
        s = lfsr_step(s);
      end
      lfsr_s = seeds[j];
      launch();
      accum(4, 0, lat);
      res_seed[j] = int'(result);
      check($sformatf("e2e_seed%0d_result", j), res_seed[j], golden);
      check($sformatf("e2e_seed%0d_latency", j), lat, 128);
      handshake();
    end
    check("e2e_seed_independent", res_seed[1], res_seed[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_stoch_to_bin
`default_nettype wire
